// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-in / payload-out / frame-status bundle for uart_rx_frame_ctrl.
// master = frame controller, slave = surrounding receiver and downstream sink.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       in_frame;

    modport master (
        input  rx_data, rx_ready, m_ready,
        output m_data, m_valid, frame_ok, frame_err, err_code, in_frame
    );

    modport slave (
        output rx_data, rx_ready, m_ready,
        input  m_data, m_valid, frame_ok, frame_err, err_code, in_frame
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Sync-hunting, length-prefixed, XOR-checked frame parser feeding a commit/rollback payload FIFO.
// Optional inter-byte timeout (error code 3) is built only when UART_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl #(
    parameter int         DEPTH          = 16,
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 37500
) (
    input logic                  clk,
    input logic                  reset_n,
    uart_rx_frame_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK} state_t;
    typedef enum logic [1:0] {E_LENGTH, E_CHECKSUM, E_OVERFLOW, E_TIMEOUT} err_t;

    logic          rx_ready_q;
    logic          byte_stb;
    logic [7:0]    byte_q;
    state_t        state, state_nxt;
    logic [7:0]    remain;
    logic [7:0]    xsum;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, rd_nxt, used;
    logic [8:0]    free_space;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    m_data_q;
    err_t          err_code_q, err_sel;
    logic          len_bad, len_ovf, chk_ok, timeout;
    logic          wr_en, rd_en, commit, rollback, frame_ok, frame_err;

    // Previous-value register resets high so a level already present at reset release is not a byte.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ready_q <= 1'b1;
            byte_stb   <= 1'b0;
            byte_q     <= '0;
        end else begin
            rx_ready_q <= bus.rx_ready;
            byte_stb   <= bus.rx_ready & ~rx_ready_q;
            if (bus.rx_ready && !rx_ready_q) byte_q <= bus.rx_data;
        end
    end

    assign used       = wr_ptr - rd_ptr;
    assign free_space = 9'(DEPTH) - 9'(used);
    assign len_bad    = (byte_q == 8'd0) || (byte_q > 8'(MAX_LEN));
    assign len_ovf    = {1'b0, byte_q} > free_space;
    assign chk_ok     = (xsum == byte_q);

`ifdef UART_FRAME_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       to_cnt <= '0;
        else if (byte_stb || state == S_HUNT) to_cnt <= '0;
        else                                to_cnt <= to_cnt + 16'd1;
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = (state != S_HUNT) && !byte_stb && (to_cnt == 16'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |16'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_HUNT;
        else          state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_HUNT;
        end else if (byte_stb) begin
            case (state)
                S_HUNT:    if (byte_q == SYNC_BYTE) state_nxt = S_LEN;
                S_LEN:     state_nxt = (len_bad || len_ovf) ? S_HUNT : S_PAYLOAD;
                S_PAYLOAD: if (remain == 8'd1) state_nxt = S_CHECK;
                S_CHECK:   state_nxt = S_HUNT;
                default:   state_nxt = S_HUNT;
            endcase
        end
    end

    always_comb begin
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        rollback  = 1'b0;
        err_sel   = err_code_q;
        if (timeout) begin
            frame_err = 1'b1;
            rollback  = 1'b1;
            err_sel   = E_TIMEOUT;
        end else if (byte_stb) begin
            case (state)
                S_LEN: begin
                    if (len_bad) begin
                        frame_err = 1'b1;
                        rollback  = 1'b1;
                        err_sel   = E_LENGTH;
                    end else if (len_ovf) begin
                        frame_err = 1'b1;
                        rollback  = 1'b1;
                        err_sel   = E_OVERFLOW;
                    end
                end
                S_PAYLOAD: wr_en = 1'b1;
                S_CHECK: begin
                    if (chk_ok) begin
                        frame_ok = 1'b1;
                        commit   = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        rollback  = 1'b1;
                        err_sel   = E_CHECKSUM;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reads stop at commit_ptr, so rollback of the tentative region never disturbs a read.
    assign rd_en  = (rd_ptr != commit_ptr) && bus.m_ready;
    assign rd_nxt = rd_ptr + {{(PW-1){1'b0}}, rd_en};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remain     <= '0;
            xsum       <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            err_code_q <= E_LENGTH;
            m_data_q   <= '0;
        end else begin
            if (byte_stb && state == S_LEN) begin
                remain <= byte_q;
                xsum   <= byte_q;
            end
            if (wr_en) begin
                remain <= remain - 8'd1;
                xsum   <= xsum ^ byte_q;
            end
            if (rollback)   wr_ptr <= commit_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            if (commit)     commit_ptr <= wr_ptr;
            if (frame_err)  err_code_q <= err_sel;
            rd_ptr   <= rd_nxt;
            m_data_q <= mem[rd_nxt[AW-1:0]];
        end
    end

    // NOTE: the payload array is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= byte_q;
    end

    assign bus.m_data    = m_data_q;
    assign bus.m_valid   = (rd_ptr != commit_ptr);
    assign bus.frame_ok  = frame_ok;
    assign bus.frame_err = frame_err;
    assign bus.err_code  = err_code_q;
    assign bus.in_frame  = (state != S_HUNT);
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized bench for uart_rx_frame_ctrl: a frame-level model predicts committed payload and
// frame events; one compare process checks the DUT every cycle, directed cases pin the model.
module tb_uart_rx_frame_ctrl;
    localparam int         DEPTH   = 16;
    localparam int         MAX_LEN = 8;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic clk = 1'b0;
    logic reset_n;

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ev_q[$];
    bit         mf_active = 1'b0;
    logic [7:0] mf_bytes[$];
    logic [1:0] exp_code = 2'd0;
    int         mr_mode = 1;
    int         ok_seen = 0;
    int         err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: collect bytes after SYNC and decide once the frame is complete.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        if (!mf_active) begin
            if (b == SYNC) begin
                mf_active = 1'b1;
                mf_bytes.delete();
            end
        end else begin
            mf_bytes.push_back(b);
            if (mf_bytes.size() == 1) begin
                if (b == 8'd0 || int'(b) > MAX_LEN) begin
                    ev_q.push_back(0);
                    mf_active = 1'b0;
                end else if (int'(b) > DEPTH - exp_q.size()) begin
                    ev_q.push_back(2);
                    mf_active = 1'b0;
                end
            end else if (mf_bytes.size() == int'(mf_bytes[0]) + 2) begin
                x = 8'd0;
                for (int i = 0; i < mf_bytes.size() - 1; i++) x ^= mf_bytes[i];
                if (x == b) begin
                    for (int i = 1; i < mf_bytes.size() - 1; i++) exp_q.push_back(mf_bytes[i]);
                    ev_q.push_back(4);
                end else begin
                    ev_q.push_back(1);
                end
                mf_active = 1'b0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte has been acted on.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        model_byte(b);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check("in_frame", {31'd0, bus.in_frame}, {31'd0, mf_active});
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic build_frame(input logic [7:0] pl[$], input logic [7:0] chk_flip,
                               output logic [7:0] f[$]);
        logic [7:0] c;
        c = 8'(pl.size());
        f.delete();
        f.push_back(SYNC);
        f.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            f.push_back(pl[i]);
            c ^= pl[i];
        end
        f.push_back(c ^ chk_flip);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_complete", exp_q.size(), 0);
    endtask

    task automatic apply_reset_mid_frame();
        reset_n = 1'b0;
        exp_q.delete();
        ev_q.delete();
        mf_bytes.delete();
        mf_active = 1'b0;
        #1;
        check("rst_m_valid", {31'd0, bus.m_valid}, 0);
        check("rst_frame_ok", {31'd0, bus.frame_ok}, 0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 0);
        check("rst_in_frame", {31'd0, bus.in_frame}, 0);
        check("rst_err_code", {30'd0, bus.err_code}, 0);
        check("rst_m_data", {24'd0, bus.m_data}, 0);
        bus.rx_data  = SYNC;
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_release_no_capture", {31'd0, bus.in_frame}, 0);
        check("rst_fifo_empty", {31'd0, bus.m_valid}, 0);
        bus.rx_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = (mr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mr_mode);
        end
    end

    // Per-cycle compare against the model.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_code = 2'd0;
                continue;
            end
            check("err_code", {30'd0, bus.err_code}, {30'd0, exp_code});
            if (exp_q.size() == 0) begin
                check("m_valid_without_commit", {31'd0, bus.m_valid}, 0);
            end else if (bus.m_valid && bus.m_ready) begin
                got_q.push_back(bus.m_data);
                check("m_data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
            end
            if (bus.frame_ok || bus.frame_err) begin
                e = (ev_q.size() > 0) ? ev_q.pop_front() : 7;
                check("event_kind", {30'd0, bus.frame_ok, bus.frame_err},
                      (e == 4) ? 32'd2 : ((e < 4) ? 32'd1 : 32'd0));
                if (bus.frame_ok) ok_seen++;
                if (bus.frame_err) begin
                    err_seen++;
                    if (e < 4) exp_code = 2'(e);
                end
            end
        end
    end

    initial begin
        logic [7:0] s[$];
        logic [7:0] pl[$];
        logic [7:0] f[$];
        int         kind;
        int         len;

        reset_n      = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m_valid", {31'd0, bus.m_valid}, 0);
        check("reset_in_frame", {31'd0, bus.in_frame}, 0);
        check("reset_err_code", {30'd0, bus.err_code}, 0);
        check("reset_m_data", {24'd0, bus.m_data}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Good frame with leading noise byte.
        got_q.delete();
        s = {8'h55, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq(s);
        wait_drain(200);
        check("good_ok_pulses", ok_seen, 1);
        check("good_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("good_b0", {24'd0, got_q[0]}, 32'h11);
            check("good_b1", {24'd0, got_q[1]}, 32'h22);
            check("good_b2", {24'd0, got_q[2]}, 32'h33);
        end

        // Bad checksum (expected FD, sent 00), then a clean frame.
        s = {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        send_seq(s);
        check("badchk_err_pulses", err_seen, 1);
        check("badchk_code", {30'd0, bus.err_code}, 1);
        got_q.delete();
        pl = {8'hAA, 8'hBB};
        build_frame(pl, 8'd0, f);
        send_seq(f);
        wait_drain(200);
        check("after_bad_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("after_bad_b0", {24'd0, got_q[0]}, 32'hAA);
            check("after_bad_b1", {24'd0, got_q[1]}, 32'hBB);
        end

        // Length errors; the LEN byte is never re-read as a sync.
        s = {8'hA5, 8'h00};
        send_seq(s);
        check("len0_code", {30'd0, bus.err_code}, 0);
        s = {8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        send_seq(s);
        check("chk_code_before_len9", {30'd0, bus.err_code}, 1);
        s = {8'hA5, 8'h09};
        send_seq(s);
        check("len9_code", {30'd0, bus.err_code}, 0);
        s = {8'hA5, 8'hA5};
        send_seq(s);
        check("len_a5_hunt", {31'd0, bus.in_frame}, 0);

        // Overflow: fill 16 entries with m_ready low, then a 1-byte frame.
        mr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        for (int fr = 0; fr < 2; fr++) begin
            pl.delete();
            for (int i = 0; i < 8; i++) pl.push_back(8'(fr * 8 + i + 1));
            build_frame(pl, 8'd0, f);
            send_seq(f);
        end
        check("ovf_valid_held", {31'd0, bus.m_valid}, 1);
        s = {8'hA5, 8'h01};
        send_seq(s);
        check("ovf_code", {30'd0, bus.err_code}, 2);
        mr_mode = 1;
        wait_drain(200);
        check("ovf_drain_count", got_q.size(), 16);
        for (int k = 0; k < got_q.size() && k < 16; k++)
            check("ovf_order", {24'd0, got_q[k]}, k + 1);

        // Stalled frame.
        s = {8'hA5, 8'h04, 8'h01};
        send_seq(s);
`ifdef UART_FRAME_TIMEOUT_EN
        ev_q.push_back(3);
        mf_active = 1'b0;
        for (int i = 0; i < 40000 && bus.in_frame; i++) @(posedge clk);
        #1;
        check("timeout_exit", {31'd0, bus.in_frame}, 0);
        check("timeout_code", {30'd0, bus.err_code}, 3);
        mr_mode = 0;
        pl = {8'h42};
        build_frame(pl, 8'd0, f);
        send_seq(f);
        s = {8'hA5, 8'h04, 8'h01, 8'h02};
        send_seq(s);
        check("pre_reset_valid", {31'd0, bus.m_valid}, 1);
`else
        repeat (40000) @(posedge clk);
        #1;
        check("stall_in_frame", {31'd0, bus.in_frame}, 1);
`endif
        apply_reset_mid_frame();
        mr_mode = 1;

        got_q.delete();
        pl = {8'h5A, 8'hC3, 8'h0F};
        build_frame(pl, 8'd0, f);
        send_seq(f);
        wait_drain(200);
        check("post_reset_count", got_q.size(), 3);

        // Randomized traffic with random backpressure.
        mr_mode = 2;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2000 && exp_q.size() + MAX_LEN > DEPTH; i++) @(posedge clk);
            #1;
            kind = $urandom_range(0, 9);
            if (kind <= 7) begin
                len = $urandom_range(1, MAX_LEN);
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
                build_frame(pl, (kind >= 6) ? 8'($urandom_range(1, 255)) : 8'd0, f);
                send_seq(f);
            end else if (kind == 8) begin
                s = {SYNC, ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(9, 255))};
                send_seq(s);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    send_byte((8'($urandom) == SYNC) ? 8'h5A : 8'($urandom_range(0, 164)));
                end
            end
        end

        mr_mode = 1;
        wait_drain(500);
        repeat (10) @(posedge clk);
        #1;
        check("events_all_seen", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
